// File: rtl/div_serial_pkg.sv
// Shared limits and modular-reduction helpers for the serial
// divisibility checker.
package div_serial_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 255;
  localparam int W_MIN = 1;
  localparam int W_MAX = 8;
  localparam int VW    = 9;

  function automatic int rem_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // (2*r + b) mod n, valid while r < n
  function automatic logic [VW-1:0] red_step(
    input logic [VW-1:0] r,
    input logic          b,
    input logic [VW-1:0] n
  );
    logic [VW-1:0] v;
    v = VW'({r, b});
    return (v >= n) ? v - n : v;
  endfunction

  function automatic logic [VW-1:0] add_mod(
    input logic [VW-1:0] a,
    input logic [VW-1:0] b,
    input logic [VW-1:0] n
  );
    logic [VW-1:0] v;
    v = a + b;
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/div_digit_reduce.sv
// Folds one W-bit digit into the running remainder (and weight
// in LSB-first mode) without a divider.
module div_digit_reduce
  import div_serial_pkg::*;
#(
  parameter int N         = 3,
  parameter int W         = 1,
  parameter int LSB_FIRST = 0,
  localparam int RW       = rem_width(N)
) (
  input  logic [RW-1:0] base_rem,
  input  logic [RW-1:0] base_wt,
  input  logic [W-1:0]  digit,
  output logic [RW-1:0] rem_nxt,
  output logic [RW-1:0] wt_nxt
);

  localparam logic [VW-1:0] NV = VW'(N);

  if (LSB_FIRST == 0) begin : g_msb
    always_comb begin
      logic [VW-1:0] r;
      r = VW'(base_rem);
      for (int i = W - 1; i >= 0; i--) begin
        r = red_step(r, digit[i], NV);
      end
      rem_nxt = RW'(r);
    end
    assign wt_nxt = base_wt;
  end else begin : g_lsb
    // digit*wt by shift-and-add, every partial kept below N
    always_comb begin
      logic [VW-1:0] p;
      logic [VW-1:0] w;
      logic [VW-1:0] s;
      p = '0;
      w = VW'(base_wt);
      for (int i = W - 1; i >= 0; i--) begin
        p = red_step(p, 1'b0, NV);
        if (digit[i]) p = add_mod(p, w, NV);
      end
      s = add_mod(VW'(base_rem), p, NV);
      rem_nxt = RW'(s);
      for (int i = 0; i < W; i++) begin
        w = red_step(w, 1'b0, NV);
      end
      wt_nxt = RW'(w);
    end
  end

endmodule

// File: rtl/div_by_n_serial.sv
// Streams a dividend one digit per beat and reports, per frame,
// the value mod N, a divisibility flag and the beat count.
module div_by_n_serial
  import div_serial_pkg::*;
#(
  parameter int N         = 3,
  parameter int W         = 1,
  parameter int LSB_FIRST = 0,
  parameter int CNT_W     = 16,
  localparam int RW       = rem_width(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    out_rem,
  output logic             out_div,
  output logic [CNT_W-1:0] out_beats,
  output logic             div_o
);

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("div_by_n_serial: N out of range");
  end
  if (W < W_MIN || W > W_MAX) begin : g_bad_w
    $error("div_by_n_serial: W out of range");
  end

  logic [RW-1:0]    rem_q, rem_d, wt_q, wt_d;
  logic [RW-1:0]    base_rem, base_wt;
  logic [RW-1:0]    rem_nxt, wt_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt, cnt_nxt;
  logic             start_q, start_d;
  logic             divo_q, divo_d;
  logic             ov_q, ov_d;
  logic [RW-1:0]    orem_q, orem_d;
  logic             odiv_q, odiv_d;
  logic [CNT_W-1:0] obeats_q, obeats_d;
  logic             accept, fresh;

  assign in_ready = !ov_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign fresh    = in_first || start_q;

  div_digit_reduce #(
    .N         (N),
    .W         (W),
    .LSB_FIRST (LSB_FIRST)
  ) u_reduce (
    .base_rem (base_rem),
    .base_wt  (base_wt),
    .digit    (in_data),
    .rem_nxt  (rem_nxt),
    .wt_nxt   (wt_nxt)
  );

  always_comb begin
    base_rem = fresh ? '0 : rem_q;
    base_wt  = fresh ? RW'(1) : wt_q;
    base_cnt = fresh ? '0 : cnt_q;
    cnt_nxt  = (&base_cnt) ? base_cnt : base_cnt + CNT_W'(1);
    rem_d    = rem_q;
    wt_d     = wt_q;
    cnt_d    = cnt_q;
    start_d  = start_q;
    divo_d   = divo_q;
    ov_d     = ov_q;
    orem_d   = orem_q;
    odiv_d   = odiv_q;
    obeats_d = obeats_q;
    if (accept) begin
      rem_d   = rem_nxt;
      wt_d    = wt_nxt;
      cnt_d   = cnt_nxt;
      start_d = in_last;
      divo_d  = (rem_nxt == '0);
    end
    if (ov_q && out_ready) ov_d = 1'b0;
    // a last beat refills the slot in the same cycle it drains
    if (accept && in_last) begin
      ov_d     = 1'b1;
      orem_d   = rem_nxt;
      odiv_d   = (rem_nxt == '0);
      obeats_d = cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q    <= '0;
      wt_q     <= RW'(1);
      cnt_q    <= '0;
      start_q  <= 1'b1;
      divo_q   <= 1'b1;
      ov_q     <= 1'b0;
      orem_q   <= '0;
      odiv_q   <= 1'b0;
      obeats_q <= '0;
    end else begin
      rem_q    <= rem_d;
      wt_q     <= wt_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      divo_q   <= divo_d;
      ov_q     <= ov_d;
      orem_q   <= orem_d;
      odiv_q   <= odiv_d;
      obeats_q <= obeats_d;
    end
  end

  assign out_valid = ov_q;
  assign out_rem   = orem_q;
  assign out_div   = odiv_q;
  assign out_beats = obeats_q;
  assign div_o     = divo_q;

endmodule

// File: tb/tb_div_by_n_serial.sv
// Self-checking bench: five configurations against a frame-value
// model plus hand-computed directed results.
module tb_div_by_n_serial;

  logic       clk;
  logic       rst_n;
  logic       v, ff, ll, ordy;
  logic [7:0] dd;
  int         sel;
  int         checks = 0;
  int         failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rdy, a_ov, a_div, a_divo;
  logic [1:0] a_rem;
  logic [15:0] a_beats;
  logic b_rdy, b_ov, b_div, b_divo;
  logic [2:0] b_rem;
  logic [15:0] b_beats;
  logic c_rdy, c_ov, c_div, c_divo;
  logic [2:0] c_rem;
  logic [1:0] c_beats;
  logic d_rdy, d_ov, d_div, d_divo;
  logic [1:0] d_rem;
  logic [15:0] d_beats;
  logic e_rdy, e_ov, e_div, e_divo;
  logic [3:0] e_rem;
  logic [15:0] e_beats;

  div_by_n_serial #(.N(3), .W(1), .LSB_FIRST(0), .CNT_W(16)) u_a (
    .clk(clk), .reset_n(rst_n), .in_valid(v && sel == 0),
    .in_ready(a_rdy), .in_data(dd[0:0]), .in_first(ff),
    .in_last(ll), .out_valid(a_ov),
    .out_ready(sel == 0 ? ordy : 1'b1), .out_rem(a_rem),
    .out_div(a_div), .out_beats(a_beats), .div_o(a_divo));

  div_by_n_serial #(.N(5), .W(4), .LSB_FIRST(0), .CNT_W(16)) u_b (
    .clk(clk), .reset_n(rst_n), .in_valid(v && sel == 1),
    .in_ready(b_rdy), .in_data(dd[3:0]), .in_first(ff),
    .in_last(ll), .out_valid(b_ov),
    .out_ready(sel == 1 ? ordy : 1'b1), .out_rem(b_rem),
    .out_div(b_div), .out_beats(b_beats), .div_o(b_divo));

  div_by_n_serial #(.N(7), .W(1), .LSB_FIRST(1), .CNT_W(2)) u_c (
    .clk(clk), .reset_n(rst_n), .in_valid(v && sel == 2),
    .in_ready(c_rdy), .in_data(dd[0:0]), .in_first(ff),
    .in_last(ll), .out_valid(c_ov),
    .out_ready(sel == 2 ? ordy : 1'b1), .out_rem(c_rem),
    .out_div(c_div), .out_beats(c_beats), .div_o(c_divo));

  div_by_n_serial #(.N(3), .W(2), .LSB_FIRST(0), .CNT_W(16)) u_d (
    .clk(clk), .reset_n(rst_n), .in_valid(v && sel == 3),
    .in_ready(d_rdy), .in_data(dd[1:0]), .in_first(ff),
    .in_last(ll), .out_valid(d_ov),
    .out_ready(sel == 3 ? ordy : 1'b1), .out_rem(d_rem),
    .out_div(d_div), .out_beats(d_beats), .div_o(d_divo));

  div_by_n_serial #(.N(11), .W(3), .LSB_FIRST(1), .CNT_W(16)) u_e (
    .clk(clk), .reset_n(rst_n), .in_valid(v && sel == 4),
    .in_ready(e_rdy), .in_data(dd[2:0]), .in_first(ff),
    .in_last(ll), .out_valid(e_ov),
    .out_ready(sel == 4 ? ordy : 1'b1), .out_rem(e_rem),
    .out_div(e_div), .out_beats(e_beats), .div_o(e_divo));

  logic        g_rdy, g_ov, g_div, g_divo;
  logic [7:0]  g_rem;
  logic [15:0] g_beats;
  int          cN, cW, cL, cMax;

  always_comb begin
    g_rdy = a_rdy; g_ov = a_ov; g_div = a_div; g_divo = a_divo;
    g_rem = 8'(a_rem); g_beats = a_beats;
    cN = 3; cW = 1; cL = 0; cMax = 65535;
    case (sel)
      1: begin
        g_rdy = b_rdy; g_ov = b_ov; g_div = b_div; g_divo = b_divo;
        g_rem = 8'(b_rem); g_beats = b_beats;
        cN = 5; cW = 4;
      end
      2: begin
        g_rdy = c_rdy; g_ov = c_ov; g_div = c_div; g_divo = c_divo;
        g_rem = 8'(c_rem); g_beats = 16'(c_beats);
        cN = 7; cL = 1; cMax = 3;
      end
      3: begin
        g_rdy = d_rdy; g_ov = d_ov; g_div = d_div; g_divo = d_divo;
        g_rem = 8'(d_rem); g_beats = d_beats;
        cW = 2;
      end
      4: begin
        g_rdy = e_rdy; g_ov = e_ov; g_div = e_div; g_divo = e_divo;
        g_rem = 8'(e_rem); g_beats = e_beats;
        cN = 11; cW = 3; cL = 1;
      end
      default: ;
    endcase
  end

  // Model: whole frame value as an integer, reduced only at the end
  longint m_val, m_nv;
  int     m_pos, m_np, m_cnt, m_nc, m_rem, m_beats;
  bit     m_in, m_fresh, m_divo, m_ov, m_div;
  logic   m_rdy, m_acc;
  int     wmask;

  assign m_rdy = !m_ov || ordy;
  assign m_acc = v && m_rdy;

  always_comb begin
    wmask   = (1 << cW) - 1;
    m_fresh = ff || !m_in;
    m_np    = m_fresh ? 0 : m_pos;
    m_nv    = m_fresh ? 0 : m_val;
    if (cL != 0) m_nv = m_nv + (longint'(dd & wmask) << (cW * m_np));
    else m_nv = (m_nv << cW) + longint'(dd & wmask);
    m_nc = m_fresh ? 0 : m_cnt;
    if (m_nc < cMax) m_nc = m_nc + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val <= 0; m_pos <= 0; m_cnt <= 0; m_in <= 0;
      m_divo <= 1; m_ov <= 0; m_rem <= 0; m_div <= 0; m_beats <= 0;
    end else begin
      if (m_ov && ordy) m_ov <= 0;
      if (m_acc) begin
        m_val  <= m_nv;
        m_pos  <= m_np + 1;
        m_cnt  <= m_nc;
        m_divo <= (m_nv % cN) == 0;
        m_in   <= !ll;
        if (ll) begin
          m_ov    <= 1;
          m_rem   <= int'(m_nv % cN);
          m_div   <= (m_nv % cN) == 0;
          m_beats <= m_nc;
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic lit(input string name, input longint dut,
                     input longint mdl, input longint exp);
    chk({name, "_dut"}, dut, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  always @(negedge clk) begin
    chk("cmp_in_ready", g_rdy, m_rdy);
    chk("cmp_out_valid", g_ov, m_ov);
    chk("cmp_div_o", g_divo, m_divo);
    if (m_ov || !rst_n) begin
      chk("cmp_out_rem", g_rem, m_rem);
      chk("cmp_out_div", g_div, m_div);
      chk("cmp_out_beats", g_beats, m_beats);
    end
  end

  task automatic beat(input logic [7:0] d, input logic f, input logic l);
    v = 1; dd = d; ff = f; ll = l;
    @(posedge clk); #1;
    v = 0; ff = 0; ll = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_cfg(input int k);
    sel = k; rst_n = 0;
    @(posedge clk); #1;
    chk("rst_out_valid", g_ov, 0);
    chk("rst_out_rem", g_rem, 0);
    chk("rst_out_beats", g_beats, 0);
    chk("rst_out_div", g_div, 0);
    chk("rst_div_o", g_divo, 1);
    rst_n = 1;
    chk("rst_in_ready", g_rdy, 1);
  endtask

  task automatic run_frames(input int nfr);
    for (int k = 0; k < nfr; k++) begin
      int len = k % 4 + 1;
      for (int j = 0; j < len; j++) begin
        beat(8'((k * 7 + j * 5 + 3) & 255),
             j == 0 || (k % 5 == 3 && j == 1), j == len - 1);
      end
      if (k % 3 == 2) begin
        ordy = 0; idle(2); ordy = 1;
      end
    end
    idle(2);
  endtask

  initial begin
    rst_n = 1; v = 0; ff = 0; ll = 0; ordy = 1; dd = 0; sel = 0;
    #1 rst_n = 0;
    idle(2);
    rst_n = 1;

    start_cfg(0);
    beat(1, 1, 0); lit("r040_divo_b1", g_divo, m_divo, 0);
    beat(1, 0, 0); lit("r040_divo_b2", g_divo, m_divo, 1);
    beat(0, 0, 1); lit("r040_divo_b3", g_divo, m_divo, 1);
    lit("r040_valid", g_ov, m_ov, 1);
    lit("r040_rem", g_rem, m_rem, 0);
    lit("r040_div", g_div, m_div, 1);
    lit("r040_beats", g_beats, m_beats, 3);
    idle(2);

    ordy = 0;
    beat(1, 1, 0); beat(0, 0, 1);
    v = 1; dd = 1; ff = 1; ll = 1;
    repeat (3) begin
      @(posedge clk); #1;
      lit("r043_hold_rem", g_rem, m_rem, 2);
      lit("r043_hold_beats", g_beats, m_beats, 2);
      chk("r043_in_ready", g_rdy, 0);
      chk("r043_valid", g_ov, 1);
    end
    ordy = 1;
    @(posedge clk); #1;
    v = 0; ff = 0; ll = 0;
    lit("r043_b2b_valid", g_ov, m_ov, 1);
    lit("r043_b2b_rem", g_rem, m_rem, 1);
    lit("r043_b2b_beats", g_beats, m_beats, 1);
    idle(2);

    ordy = 0;
    beat(1, 1, 0); beat(1, 0, 0); beat(0, 0, 1);
    start_cfg(0);
    ordy = 1;
    beat(1, 1, 0); beat(0, 0, 0);
    start_cfg(0);
    beat(1, 0, 0); beat(0, 0, 1);
    lit("r045_rem", g_rem, m_rem, 2);
    lit("r045_beats", g_beats, m_beats, 2);
    idle(1);
    run_frames(6);

    start_cfg(1);
    beat(8'h7, 1, 0); beat(8'hB, 0, 1);
    lit("r041_rem", g_rem, m_rem, 3);
    lit("r041_div", g_div, m_div, 0);
    lit("r041_beats", g_beats, m_beats, 2);
    idle(1);
    run_frames(10);

    start_cfg(2);
    beat(1, 1, 0); beat(0, 0, 0); beat(1, 0, 0); beat(1, 0, 1);
    lit("r042_rem", g_rem, m_rem, 6);
    lit("r042_div", g_div, m_div, 0);
    idle(1);
    for (int i = 0; i < 5; i++) beat(1, i == 0, i == 4);
    lit("sat_rem", g_rem, m_rem, 3);
    lit("sat_beats", g_beats, m_beats, 3);
    idle(1);
    run_frames(6);

    start_cfg(3);
    beat(8'h3, 1, 0); beat(8'h2, 0, 0); beat(8'h2, 1, 1);
    lit("r044_rem", g_rem, m_rem, 2);
    lit("r044_beats", g_beats, m_beats, 1);
    idle(1);
    run_frames(6);

    start_cfg(4);
    beat(8'h5, 1, 0); beat(8'h3, 0, 1);
    lit("lsb_w3_rem", g_rem, m_rem, 7);
    idle(1);
    run_frames(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_by_n_serial.md
DIV_BY_N_SERIAL -- requirements
Module: div_by_n_serial

Interface
REQ-001 Parameter N, default 3: divisor, legal range 2..255.
REQ-002 Parameter W, default 1: digit bits per input beat, legal range 1..8.
REQ-003 Parameter LSB_FIRST, default 0: 0 means stream is MSB-first, 1 means LSB-first.
REQ-004 Parameter CNT_W, default 16: beat-counter width.
REQ-005 Derived constant RW = max(1, clog2(N)): remainder width.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 in_valid  in  1  input beat valid.
REQ-009 in_ready  out  1  block can accept a beat.
REQ-010 in_data  in  W  one digit of the dividend.
REQ-011 in_first  in  1  beat starts a new frame.
REQ-012 in_last  in  1  beat ends the frame.
REQ-013 out_valid  out  1  frame result valid.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 out_rem  out  RW  frame value mod N.
REQ-016 out_div  out  1  frame value divisible by N.
REQ-017 out_beats  out  CNT_W  beats in the frame, saturating.
REQ-018 div_o  out  1  registered running flag, high when the partial value seen so far is divisible by N.

Function
REQ-019 Accept a beat only when in_valid && in_ready; ignore in_data, in_first and in_last otherwise.
REQ-020 Drive in_ready = !out_valid || out_ready combinationally; throughput is one beat per cycle.
REQ-021 Frame state: remainder rem (RW bits), weight wt (RW bits, LSB mode only), beat count cnt.
REQ-022 Base values per accepted beat: if in_first or at frame start, base_rem = 0, base_wt = 1 mod N and base_cnt = 0; otherwise base_rem = rem, base_wt = wt and base_cnt = cnt.
REQ-023 MSB mode next remainder: rem' = (base_rem*2^W + in_data) mod N, computed as W sequential shift-and-subtract reductions, no divider.
REQ-024 LSB mode next remainder: rem' = (base_rem + in_data*base_wt) mod N; wt' = (base_wt*2^W) mod N; all intermediates reduced to below N.
REQ-025 cnt' = base_cnt + 1, saturating at all-ones.
REQ-026 div_o is updated on every accepted beat to (rem' == 0) and holds otherwise.
REQ-027 Frame start holds after reset and after every accepted in_last beat.
REQ-028 An in_first beat mid-frame discards the partial frame silently; no result is produced for it.
REQ-029 in_first and in_last on the same beat form a valid one-beat frame.
REQ-030 On an accepted in_last beat, the next cycle shows out_valid=1, out_rem=rem', out_div=(rem'==0), out_beats=cnt'; latency is 1 cycle.
REQ-031 While out_valid && !out_ready, all result outputs hold stable.
REQ-032 On out_valid && out_ready, clear out_valid unless an in_last beat is accepted the same cycle; in that case load the new result back-to-back.

Reset
REQ-033 While reset_n=0: out_valid=0, out_rem=0, out_div=0, out_beats=0, div_o=1, rem=0, wt=1 mod N, cnt=0, frame start set.
REQ-034 Reset asserted mid-frame or with a result pending discards both with no output.
REQ-035 in_ready=1 immediately after reset.

Structure
REQ-036 A shared package div_serial_pkg holds the parameter limits, the RW derivation function and the reduction-step function.
REQ-037 One combinational sub-module, div_digit_reduce (parameters N, W, LSB_FIRST), computes rem' and wt'.
REQ-038 The top holds the frame registers, counter, result register and handshake only.
REQ-039 Elaboration fails if N or W is outside its legal range.

Verification
REQ-040 N=3, W=1, MSB: bits 1,1,0 with last on the third beat -> out_rem=0, out_div=1, out_beats=3; div_o sequence 0,1,1.
REQ-041 N=5, W=4, MSB: beats 0x7, 0xB (value 123) -> out_rem=3, out_div=0, out_beats=2.
REQ-042 N=7, W=1, LSB: bits 1,0,1,1 (value 13) -> out_rem=6, out_div=0.
REQ-043 Hold out_ready=0 for 3 cycles after a result -> result stable, in_ready=0, no beats accepted; on out_ready=1 with a one-beat frame (N=3, data 1, first+last) arriving the same cycle -> next result out_rem=1, no bubble.
REQ-044 N=3, W=2: beats 0x3, 0x2, then in_first with 0x2 and in_last -> out_rem=2, out_beats=1 (partial frame discarded).
REQ-045 reset_n pulsed low mid-frame with a result pending -> all outputs at reset values; next frame computed from remainder 0.
